ghost_move_ctrl: RTL and testbench
==================================

Name: ghost_move_ctrl

Overview:
- Sequential wrapper around the ghost next-location decision logic.
- Owns the ghost position register and fetches the four surrounding maze rows from the single-port maze row memory.
- Presents those rows to the combinational next-location stage, then commits its chosen position.
- One move per accepted move_tick; feeds the sprite/renderer with ghost_pos.

Parameters:
- COLS, 22, maze width in cells; one memory row = COLS bits, bit c = 1 means wall at column c.
- ROWS, 22, maze height in rows; valid positions are 0..ROWS*COLS-1, encoded pos = row*COLS + col.
- START_POS, 231, ghost_pos reset value (row 10, col 11).
- RD_LAT, 1, maze memory read latency in cycles (1 or 2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- move_tick  in  1  one-cycle request to advance the ghost one cell
- target_pos  in  10  chase target, sampled on accepted tick
- mem_rd_en  out  1  maze memory read strobe
- mem_addr  out  5  maze row address
- mem_row  in  COLS  row data, valid RD_LAT cycles after mem_rd_en
- nl_row_addr  in  4x5  row addresses requested by next-loc stage, index 0=up 1=right 2=down 3=left
- nl_rows  out  4xCOLS  fetched rows returned to next-loc stage, same indexing
- nl_cur_pos  out  10  registered ghost position driven to next-loc stage
- nl_target_pos  out  10  latched target driven to next-loc stage
- nl_next_pos  in  10  next-loc stage result
- ghost_pos  out  10  current ghost cell (same value as nl_cur_pos)
- busy  out  1  high from accepted tick until move_done
- move_done  out  1  one-cycle pulse, position committed or rejected
- move_err  out  1  one-cycle pulse with move_done when nl_next_pos rejected

Behaviour:
- Reset (async, any state):
  - state=IDLE; ghost_pos=START_POS; nl_target_pos=0; nl_rows=all ones.
  - mem_rd_en=0; mem_addr=0; busy=0; move_done=0; move_err=0; pending cleared; in-flight reads discarded.
- States: IDLE -> FETCH -> DRAIN -> DECIDE -> COMMIT -> IDLE.
- IDLE: move_tick=1 -> latch target_pos into nl_target_pos, busy=1, go to FETCH.
- FETCH: 4 cycles; cycle i issues direction i with mem_addr=nl_row_addr[i].
  - If nl_row_addr[i] >= ROWS (including wrapped underflow), do not assert mem_rd_en; nl_rows[i] is forced to all ones (wall) with no memory access.
  - Otherwise mem_rd_en=1.
  - The direction index travels in an RD_LAT-deep shift register; mem_row is captured into nl_rows[idx] when its valid emerges.
- DRAIN: wait until all 4 captures are done (RD_LAT cycles after the last issue).
- DECIDE: 1 cycle; nl_rows stable; nl_next_pos sampled at end of cycle.
- COMMIT: nl_next_pos is accepted only if it equals one of the following and is < ROWS*COLS:
  - pos-COLS (row>0);
  - pos+COLS (row<ROWS-1);
  - pos-1 (col>0);
  - pos+1 (col<COLS-1).
  - Accepted: ghost_pos <= nl_next_pos.
  - Rejected: ghost_pos holds; move_err=1.
  - In both cases move_done=1 for one cycle, busy falls the following cycle, return to IDLE.
- Latency: move_done asserts 6+RD_LAT cycles after the clock edge sampling move_tick (7 for RD_LAT=1).
- ghost_pos and nl_cur_pos change only in COMMIT; stable throughout FETCH/DRAIN/DECIDE.
- Row/col derived by division/modulo by COLS on the 10-bit position; arithmetic in 11 bits to detect underflow/overflow.
- move_tick while busy: dropped (see optional feature).
- move_tick in the COMMIT cycle: treated as busy.

Optional Feature:
- Macro GHOST_TICK_PENDING_EN.
- Defined: a 1-deep pending flag records any move_tick arriving while busy. Multiple ticks collapse into one. On leaving COMMIT with pending set, go directly to FETCH (skip IDLE), re-latching target_pos in that cycle, and clear pending.
- Undefined: ticks while busy are ignored and no flag exists.

Test Plan:
- Reset release, no tick -> ghost_pos=231, busy=0, mem_rd_en=0 indefinitely.
- Model memory (RD_LAT=1) open at row 9, next-loc model returns 209; tick at cycle 0 -> mem_rd_en high cycles 1-4, move_done at cycle 7, ghost_pos=209 at cycle 8, move_err=0.
- Next-loc model returns 500 (non-neighbour) -> move_done with move_err=1, ghost_pos stays 231.
- Ghost at pos 5 (row 0), nl_row_addr[0]=31 -> only 3 mem_rd_en pulses; nl_rows[0]=all ones during DECIDE.
- Tick at cycle 0, second tick at cycle 3 -> undefined macro: exactly one move; defined: second FETCH starts the cycle after COMMIT, two move_done pulses 7 cycles apart.
- reset_n low during DRAIN -> immediate IDLE, ghost_pos=231; a late mem_row return is not captured; next tick completes normally.

Source files
------------

// File: rtl/ghost_move_ctrl.sv
// ghost_move_ctrl: ghost position register plus maze-row fetch sequencer around the next-location stage.
// Define GHOST_TICK_PENDING_EN to remember one move_tick that arrives while a move is in progress.
module ghost_move_ctrl #(
    parameter int COLS      = 22,
    parameter int ROWS      = 22,
    parameter int START_POS = 231,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 move_tick,
    input  logic [9:0]           target_pos,
    output logic                 mem_rd_en,
    output logic [4:0]           mem_addr,
    input  logic [COLS-1:0]      mem_row,
    input  logic [3:0][4:0]      nl_row_addr,
    output logic [3:0][COLS-1:0] nl_rows,
    output logic [9:0]           nl_cur_pos,
    output logic [9:0]           nl_target_pos,
    input  logic [9:0]           nl_next_pos,
    output logic [9:0]           ghost_pos,
    output logic                 busy,
    output logic                 move_done,
    output logic                 move_err
);
    localparam logic [10:0] COLS11   = 11'(COLS);
    localparam logic [10:0] AREA11   = 11'(ROWS * COLS);
    localparam logic [10:0] LASTROW  = 11'(ROWS - 1);
    localparam logic [10:0] LASTCOL  = 11'(COLS - 1);
    localparam logic [1:0]  DRAINEND = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, DECIDE, COMMIT} state_t;

    state_t                 state;
    logic [1:0]             issueIdx;
    logic [1:0]             drainCnt;
    logic [RD_LAT-1:0]      pipeVld;
    logic [RD_LAT-1:0][1:0] pipeIdx;
    logic [9:0]             nextPos;
    logic [10:0]            curPos, candPos, rowIdx, colIdx;
    logic                   nextOk;
    logic                   reTick;

    assign nl_cur_pos = ghost_pos;
    assign mem_addr   = (state == FETCH) ? nl_row_addr[issueIdx] : 5'd0;
    assign mem_rd_en  = (state == FETCH) && ({1'b0, mem_addr} < 6'(ROWS));

    // 11-bit arithmetic so pos-COLS / pos-1 underflow cannot alias a real cell
    assign curPos  = {1'b0, ghost_pos};
    assign candPos = {1'b0, nl_next_pos};
    assign rowIdx  = curPos / COLS11;
    assign colIdx  = curPos % COLS11;
    assign nextOk  = (candPos < AREA11) &&
                     ((rowIdx != 11'd0   && candPos == curPos - COLS11) ||
                      (rowIdx <  LASTROW && candPos == curPos + COLS11) ||
                      (colIdx != 11'd0   && candPos == curPos - 11'd1)  ||
                      (colIdx <  LASTCOL && candPos == curPos + 11'd1));

`ifdef GHOST_TICK_PENDING_EN
    logic pending;
    assign reTick = pending || move_tick;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pending <= 1'b0;
        else if (state == COMMIT)
            pending <= 1'b0;
        else if (state != IDLE && move_tick)
            pending <= 1'b1;
    end
`else
    assign reTick = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ghost_pos     <= 10'(START_POS);
            nl_target_pos <= '0;
            nl_rows       <= '1;
            issueIdx      <= '0;
            drainCnt      <= '0;
            pipeVld       <= '0;
            pipeIdx       <= '0;
            nextPos       <= '0;
            busy          <= 1'b0;
            move_done     <= 1'b0;
            move_err      <= 1'b0;
        end else begin
            move_done  <= 1'b0;
            move_err   <= 1'b0;
            pipeVld[0] <= mem_rd_en;
            pipeIdx[0] <= issueIdx;
            for (int i = 1; i < RD_LAT; i++) begin
                pipeVld[i] <= pipeVld[i-1];
                pipeIdx[i] <= pipeIdx[i-1];
            end
            if (pipeVld[RD_LAT-1])
                nl_rows[pipeIdx[RD_LAT-1]] <= mem_row;
            // out-of-maze rows read as solid wall without touching memory
            if (state == FETCH && !mem_rd_en)
                nl_rows[issueIdx] <= '1;
            case (state)
                IDLE: if (move_tick) begin
                    nl_target_pos <= target_pos;
                    busy          <= 1'b1;
                    issueIdx      <= '0;
                    state         <= FETCH;
                end
                FETCH: begin
                    issueIdx <= issueIdx + 2'd1;
                    drainCnt <= '0;
                    state    <= (issueIdx == 2'd3) ? DRAIN : FETCH;
                end
                DRAIN: begin
                    drainCnt <= drainCnt + 2'd1;
                    state    <= (drainCnt == DRAINEND) ? DECIDE : DRAIN;
                end
                DECIDE: begin
                    nextPos   <= nl_next_pos;
                    move_done <= 1'b1;
                    move_err  <= !nextOk;
                    state     <= COMMIT;
                end
                COMMIT: begin
                    if (!move_err)
                        ghost_pos <= nextPos;
                    if (reTick) begin
                        nl_target_pos <= target_pos;
                        issueIdx      <= '0;
                        state         <= FETCH;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ghost_move_ctrl.sv
// tb_ghost_move_ctrl: directed bench with a 1-cycle maze memory model and a simple next-location model.
module tb_ghost_move_ctrl;
    logic             clk = 1'b0;
    logic             resetN = 1'b0;
    logic             moveTick = 1'b0;
    logic [9:0]       targetPos = '0;
    logic [9:0]       nlResult = '0;
    logic             memRdEn;
    logic [4:0]       memAddr;
    logic [21:0]      memRow = '0;
    logic [3:0][4:0]  nlRowAddr;
    logic [3:0][21:0] nlRows;
    logic [9:0]       nlCurPos, nlTargetPos, ghostPos;
    logic             busy, moveDone, moveErr;
    logic [21:0]      maze [32];
    logic [4:0]       curRow;
    int               nChecks = 0;
    int               nPass = 0;
    int               doneCyc, rdCnt, dones, firstDone, gap;
    logic             err, busyDone;
    logic [3:0][21:0] rows;

    ghost_move_ctrl dut (
        .clk(clk), .reset_n(resetN), .move_tick(moveTick), .target_pos(targetPos),
        .mem_rd_en(memRdEn), .mem_addr(memAddr), .mem_row(memRow),
        .nl_row_addr(nlRowAddr), .nl_rows(nlRows), .nl_cur_pos(nlCurPos),
        .nl_target_pos(nlTargetPos), .nl_next_pos(nlResult), .ghost_pos(ghostPos),
        .busy(busy), .move_done(moveDone), .move_err(moveErr)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (memRdEn) memRow <= maze[memAddr];

    assign curRow       = 5'(nlCurPos / 10'd22);
    assign nlRowAddr[0] = curRow - 5'd1;
    assign nlRowAddr[1] = curRow;
    assign nlRowAddr[2] = curRow + 5'd1;
    assign nlRowAddr[3] = curRow;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // tick sampled at edge 0; returns at the first cycle after move_done
    task automatic doMove(input logic [9:0] tgt, input logic [9:0] res);
        logic [3:0][21:0] prevRows;
        prevRows = nlRows;
        nlResult = res;
        targetPos = tgt;
        @(negedge clk); moveTick = 1'b1;
        @(negedge clk); moveTick = 1'b0;
        doneCyc = 0; rdCnt = 0; err = 1'b0; busyDone = 1'b0; rows = '0;
        for (int c = 1; c <= 20 && doneCyc == 0; c++) begin
            if (c > 1) @(negedge clk);
            rdCnt += int'(memRdEn);
            if (moveDone) begin
                doneCyc = c; err = moveErr; busyDone = busy; rows = prevRows;
            end
            prevRows = nlRows;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) maze[r] = (r < 22) ? (22'h3FFFE0 | 22'(r)) : 22'h0;
        maze[9] = 22'h0;

        repeat (2) @(negedge clk);
        check("rst_pos", 32'(ghostPos), 231);
        check("rst_busy", 32'(busy), 0);
        check("rst_tgt", 32'(nlTargetPos), 0);
        check("rst_rows", 32'(nlRows[1]), 32'h3FFFFF);
        resetN = 1'b1;
        rdCnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rdCnt += int'(memRdEn) + int'(busy) + int'(moveDone);
        end
        check("idle_quiet", 32'(rdCnt), 0);
        check("idle_pos", 32'(ghostPos), 231);

        doMove(10'd300, 10'd500);
        check("rej_done_cyc", 32'(doneCyc), 7);
        check("rej_err", 32'(err), 1);
        check("rej_pos", 32'(ghostPos), 231);
        check("rej_done_width", 32'(moveDone), 0);

        doMove(10'd100, 10'd209);
        check("acc_done_cyc", 32'(doneCyc), 7);
        check("acc_rd_cnt", 32'(rdCnt), 4);
        check("acc_err", 32'(err), 0);
        check("acc_busy_at_done", 32'(busyDone), 1);
        check("acc_row_up", 32'(rows[0]), 32'h0);
        check("acc_row_down", 32'(rows[2]), 32'h3FFFEB);
        check("acc_tgt", 32'(nlTargetPos), 100);
        check("acc_pos", 32'(ghostPos), 209);
        check("acc_busy_after", 32'(busy), 0);

        for (int k = 0; k < 12 && (ghostPos % 10'd22) > 10'd5; k++) begin
            doMove(10'd0, ghostPos - 10'd1);
            check("walk_left_err", 32'(err), 0);
        end
        for (int k = 0; k < 12 && ghostPos >= 10'd22; k++) begin
            doMove(10'd0, ghostPos - 10'd22);
            check("walk_up_err", 32'(err), 0);
        end
        check("walk_pos", 32'(ghostPos), 5);

        doMove(10'd0, 10'd1007);
        check("top_rd_cnt", 32'(rdCnt), 3);
        check("top_row_wall", 32'(rows[0]), 32'h3FFFFF);
        check("top_row_down", 32'(rows[2]), 32'h3FFFE1);
        check("top_err", 32'(err), 1);
        check("top_pos", 32'(ghostPos), 5);

        for (int k = 0; k < 8 && ghostPos != 10'd0; k++) doMove(10'd0, ghostPos - 10'd1);
        doMove(10'd0, 10'd22);
        check("edge_pos", 32'(ghostPos), 22);
        doMove(10'd0, 10'd21);
        check("edge_wrap_err", 32'(err), 1);
        check("edge_wrap_pos", 32'(ghostPos), 22);

        nlResult = 10'd0;
        targetPos = 10'd40;
        @(negedge clk); moveTick = 1'b1;
        dones = 0; firstDone = 0; gap = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            moveTick = (c == 3);
            if (c == 3) targetPos = 10'd77;
            if (c == 8) nlResult = 10'd1;
            if (moveDone) begin
                dones++;
                if (firstDone == 0) firstDone = c;
                else gap = c - firstDone;
            end
        end
        moveTick = 1'b0;
        check("busy_first_done", 32'(firstDone), 7);
`ifdef GHOST_TICK_PENDING_EN
        check("busy_dones", 32'(dones), 2);
        check("busy_gap", 32'(gap), 7);
        check("busy_pos", 32'(ghostPos), 1);
        check("busy_tgt", 32'(nlTargetPos), 77);
`else
        check("busy_dones", 32'(dones), 1);
        check("busy_pos", 32'(ghostPos), 0);
        check("busy_tgt", 32'(nlTargetPos), 40);
`endif
        check("busy_idle", 32'(busy), 0);

        nlResult = 10'd2;
        @(negedge clk); moveTick = 1'b1;
        @(negedge clk); moveTick = 1'b0;
        repeat (4) @(negedge clk);
        check("drain_busy", 32'(busy), 1);
        resetN = 1'b0;
        #1;
        check("drain_rst_pos", 32'(ghostPos), 231);
        check("drain_rst_busy", 32'(busy), 0);
        @(negedge clk); resetN = 1'b1;
        repeat (3) @(negedge clk);
        check("drain_no_capture", 32'(nlRows[3]), 32'h3FFFFF);
        check("drain_no_done", 32'(moveDone), 0);
        doMove(10'd9, 10'd232);
        check("post_rst_done_cyc", 32'(doneCyc), 7);
        check("post_rst_err", 32'(err), 0);
        check("post_rst_pos", 32'(ghostPos), 232);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
